// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues reads to a 1-cycle-latency
// instruction memory and buffers returned words for decode in a 3-deep FIFO.
module instr_fetch #(
    parameter int unsigned INSTR_LEN = 20,
    parameter int unsigned ADDR      = 5,
    parameter int unsigned LAST_ADDR = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 redirect,
    input  logic [ADDR-1:0]      redirect_addr,
    output logic                 mem_rd_en,
    output logic [ADDR-1:0]      mem_rd_addr,
    input  logic [INSTR_LEN-1:0] mem_rd_data,
    output logic                 instr_valid,
    output logic [INSTR_LEN-1:0] instr,
    output logic [ADDR-1:0]      instr_pc,
    input  logic                 instr_ready,
    output logic                 done
);

    localparam int unsigned DEPTH = 3;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned OCC_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR-1:0]      pc;
        logic [INSTR_LEN-1:0] word;
    } entry_t;

    state_e               state_q, state_d;
    logic [ADDR-1:0]      pc_q, pc_d;
    logic                 inflight_q, inflight_d;
    logic [ADDR-1:0]      inflight_pc_q, inflight_pc_d;
    logic                 done_q, done_d;
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    entry_t               fifo_q [DEPTH];

    logic                 issue;
    logic                 push;
    logic                 pop;
    logic [OCC_W-1:0]     outstanding;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Buffered plus in-flight words; issue only while there is room for the return.
    assign outstanding = OCC_W'(count_q) + OCC_W'(inflight_q);

    // State register and control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            done_q        <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            done_q        <= done_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // FIFO storage: written with the returning word tagged by its fetch address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[tail_q] <= '{pc: inflight_pc_q, word: mem_rd_data};
        end
    end

    // Next-state, issue and buffer bookkeeping.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        done_d        = done_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;

        issue = (state_q == RUN) && !redirect && (outstanding < OCC_W'(DEPTH));
        pop   = (count_q != '0) && instr_ready;
        push  = inflight_q && !redirect;

        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        if (push) begin
            tail_d = ptr_inc(tail_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (issue) begin
            pc_d          = pc_q + ADDR'(1);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end

        // A redirect keeps only a head handshake already in progress.
        if (redirect) begin
            pc_d    = redirect_addr;
            done_d  = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (!redirect && en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (issue && (pc_q == ADDR'(LAST_ADDR))) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (!en) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (redirect) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_rd_en   = issue;
    assign mem_rd_addr = pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = fifo_q[head_q].word;
    assign instr_pc    = fifo_q[head_q].pc;
    assign done        = done_q;

endmodule
